rv32v_hazard_unit: RTL and testbench

Pipeline hazard controller for the RV32V-capable core. It consumes the busy, stage-valid, vector-busy and vector-done indications published by fetch, decode, execute, memory, writeback and the ROB, and drives every stage's stall/flush plus the decode-side `v_decode_done` pulse. It tracks outstanding vector instructions between decode hand-off and ROB completion, serializes CSR updates against them, and sequences exception flushes.

---
 rtl/rv32v_hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_rv32v_hazard_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv32v_hazard_unit.sv
// rv32v_hazard_unit: pipeline hazard controller for the RV32V core.
// Drives the per-stage stall/flush controls from stage busy/valid indications,
// tracks vector instructions between decode hand-off and ROB completion,
// serializes CSR writes against outstanding vector work and sequences
// exception flushes.
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   busy_f1/f2/dec/ex/mem          stage cannot accept/advance
//   decode/execute/memory/writeback_ena  stage holds a valid instruction
//   csr_update                     memory stage committing a CSR write (level)
//   exception_v                    exception at memory (single-cycle)
//   v_busy                         vector decode latch occupied
//   v_done                         ROB completion pulse per vector instruction
//   stall_f1/f2/dec/ex/mem         hold stage register (combinational)
//   flush_f1/f2/dec/ex/mem         invalidate stage register (combinational)
//   v_decode_done                  registered pulse: vector released by decode
module rv32v_hazard_unit #(
    parameter int unsigned MAX_VOUT = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic busy_f1,
    input  logic busy_f2,
    input  logic busy_dec,
    input  logic busy_ex,
    input  logic busy_mem,
    input  logic decode_ena,
    input  logic execute_ena,
    input  logic memory_ena,
    input  logic writeback_ena,
    input  logic csr_update,
    input  logic exception_v,
    input  logic v_busy,
    input  logic v_done,
    output logic stall_f1,
    output logic stall_f2,
    output logic stall_dec,
    output logic stall_ex,
    output logic stall_mem,
    output logic flush_f1,
    output logic flush_f2,
    output logic flush_dec,
    output logic flush_ex,
    output logic flush_mem,
    output logic v_decode_done
);

    localparam int unsigned CW = $clog2(MAX_VOUT + 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CSR_WAIT  = 2'd1,
        CSR_FLUSH = 2'd2,
        EXC_FLUSH = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   vcnt, vcnt_nxt;
    logic            v_busy_q;
    logic            vfull;
    logic            vcnt_zero;
    logic            run_mem, run_ex, run_dec, run_f2, run_f1;
    logic            vdd_nxt;
    logic            cnt_inc, cnt_dec;

    // Memory/writeback valids do not gate any hazard today; kept on the port list.
    logic            unused_ena;
    assign unused_ena = memory_ena ^ writeback_ena;

    assign vfull     = (vcnt == CW'(MAX_VOUT));
    assign vcnt_zero = (vcnt == '0);

    // Backpressure chain used in RUN and EXC_FLUSH.
    assign run_mem = busy_mem;
    assign run_ex  = run_mem | (busy_ex & execute_ena);
    assign run_dec = run_ex | (busy_dec & decode_ena) | v_busy | (vfull & decode_ena);
    assign run_f2  = run_dec | busy_f2;
    assign run_f1  = run_f2 | busy_f1;

    // Next-state and stall/flush decode; exception overrides everything.
    always_comb begin
        state_nxt = state;
        stall_mem = run_mem;
        stall_ex  = run_ex;
        stall_dec = run_dec;
        stall_f2  = run_f2;
        stall_f1  = run_f1;
        flush_f1  = 1'b0;
        flush_f2  = 1'b0;
        flush_dec = 1'b0;
        flush_ex  = 1'b0;
        flush_mem = 1'b0;

        case (state)
            RUN: begin
                if (csr_update) begin
                    state_nxt = vcnt_zero ? CSR_FLUSH : CSR_WAIT;
                end
            end
            CSR_WAIT: begin
                {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b11111;
                if (vcnt_zero) begin
                    state_nxt = CSR_FLUSH;
                end
            end
            CSR_FLUSH: begin
                {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b00000;
                {flush_f1, flush_f2, flush_dec, flush_ex} = 4'b1111;
                state_nxt = RUN;
            end
            EXC_FLUSH: begin
                // Kill fetch responses still in flight; a flush beats a stall.
                flush_f1  = 1'b1;
                flush_f2  = 1'b1;
                stall_f1  = 1'b0;
                stall_f2  = 1'b0;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        if (exception_v) begin
            {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem} = 5'b00000;
            {flush_f1, flush_f2, flush_dec, flush_ex, flush_mem} = 5'b11111;
            state_nxt = EXC_FLUSH;
        end
    end

    // Hand-off pulse; an excepting cycle flushes the instruction, so no release.
    assign vdd_nxt = v_busy_q & ~v_busy & ~stall_dec & ~exception_v;

    // Outstanding vector counter: saturates at MAX_VOUT, ignores v_done at zero.
    assign cnt_inc = v_decode_done;
    assign cnt_dec = v_done & ~vcnt_zero;

    always_comb begin
        vcnt_nxt = vcnt;
        if (exception_v) begin
            vcnt_nxt = '0;
        end else if (cnt_inc && !cnt_dec && !vfull) begin
            vcnt_nxt = vcnt + CW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            vcnt_nxt = vcnt - CW'(1);
        end
    end

    // State, counter and hand-off registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= RUN;
            vcnt          <= '0;
            v_busy_q      <= 1'b0;
            v_decode_done <= 1'b0;
        end else begin
            state         <= state_nxt;
            vcnt          <= vcnt_nxt;
            v_busy_q      <= exception_v ? 1'b0 : v_busy;
            v_decode_done <= vdd_nxt;
        end
    end

endmodule

// File: tb/tb_rv32v_hazard_unit.sv
// Directed self-checking bench for rv32v_hazard_unit.
// Outputs are packed as {stall_f1,f2,dec,ex,mem, flush_f1,f2,dec,ex,mem}.
module tb_rv32v_hazard_unit;

    logic CLK = 1'b0;
    logic nRST;
    logic busy_f1, busy_f2, busy_dec, busy_ex, busy_mem;
    logic decode_ena, execute_ena, memory_ena, writeback_ena;
    logic csr_update, exception_v, v_busy, v_done;
    logic stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
    logic flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
    logic v_decode_done;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    rv32v_hazard_unit #(.MAX_VOUT(4)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .busy_f1      (busy_f1),
        .busy_f2      (busy_f2),
        .busy_dec     (busy_dec),
        .busy_ex      (busy_ex),
        .busy_mem     (busy_mem),
        .decode_ena   (decode_ena),
        .execute_ena  (execute_ena),
        .memory_ena   (memory_ena),
        .writeback_ena(writeback_ena),
        .csr_update   (csr_update),
        .exception_v  (exception_v),
        .v_busy       (v_busy),
        .v_done       (v_done),
        .stall_f1     (stall_f1),
        .stall_f2     (stall_f2),
        .stall_dec    (stall_dec),
        .stall_ex     (stall_ex),
        .stall_mem    (stall_mem),
        .flush_f1     (flush_f1),
        .flush_f2     (flush_f2),
        .flush_dec    (flush_dec),
        .flush_ex     (flush_ex),
        .flush_mem    (flush_mem),
        .v_decode_done(v_decode_done)
    );

    function automatic logic [9:0] outs();
        return {stall_f1, stall_f2, stall_dec, stall_ex, stall_mem,
                flush_f1, flush_f2, flush_dec, flush_ex, flush_mem};
    endfunction

    task automatic chk_outs(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        #1;
        got = outs();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_vdd(input string tag, input logic exp);
        checks++;
        assert (v_decode_done === exp) else begin
            errors++;
            $error("FAIL %s v_decode_done observed=%b expected=%b", tag, v_decode_done, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One full vector hand-off: v_busy high one cycle, pulse, counter increment.
    task automatic handoff();
        v_busy = 1'b1;
        tick();
        v_busy = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        nRST = 1'b0;
        {busy_f1, busy_f2, busy_dec, busy_ex, busy_mem} = '0;
        {decode_ena, execute_ena, memory_ena, writeback_ena} = '0;
        {csr_update, exception_v, v_busy, v_done} = '0;

        // Reset state
        chk_outs("reset_outs", 10'b00000_00000);
        chk_vdd("reset_vdd", 1'b0);
        #9;
        nRST = 1'b1;
        tick();

        // Backpressure
        {decode_ena, execute_ena, memory_ena, writeback_ena} = 4'b1111;
        busy_mem = 1'b1;
        chk_outs("bp_mem", 10'b11111_00000);
        busy_mem = 1'b0;
        chk_outs("bp_release", 10'b00000_00000);
        busy_ex = 1'b1;
        chk_outs("bp_ex", 10'b11110_00000);
        busy_ex = 1'b0;
        busy_f1 = 1'b1;
        chk_outs("bp_f1", 10'b10000_00000);
        busy_f1 = 1'b0;
        {decode_ena, execute_ena, memory_ena, writeback_ena} = 4'b0000;
        tick();

        // Vector hand-off: v_busy for three cycles
        v_busy = 1'b1;
        chk_outs("vbusy_c1", 10'b11100_00000);
        tick();
        chk_outs("vbusy_c2", 10'b11100_00000);
        chk_vdd("vbusy_c2_vdd", 1'b0);
        tick();
        chk_outs("vbusy_c3", 10'b11100_00000);
        tick();
        v_busy = 1'b0;
        chk_outs("vbusy_fall", 10'b00000_00000);
        chk_vdd("vdd_before", 1'b0);
        tick();
        chk_vdd("vdd_pulse", 1'b1);
        tick();
        chk_vdd("vdd_single", 1'b0);
        // Retire it; counter back to 0
        v_done = 1'b1;
        tick();
        v_done = 1'b0;

        // Full: four hand-offs fill the tracker
        handoff();
        handoff();
        handoff();
        decode_ena = 1'b1;
        chk_outs("three_not_full", 10'b00000_00000);
        decode_ena = 1'b0;
        handoff();
        decode_ena = 1'b1;
        chk_outs("full_stall", 10'b11100_00000);
        v_done = 1'b1;
        tick();
        v_done = 1'b0;
        chk_outs("full_release", 10'b00000_00000);

        // CSR serialization with vcnt=2
        v_done = 1'b1;
        tick();
        v_done = 1'b0;
        csr_update = 1'b1;
        chk_outs("csr_run", 10'b00000_00000);
        tick();
        chk_outs("csr_wait", 10'b11111_00000);
        v_done = 1'b1;
        tick();
        v_done = 1'b0;
        chk_outs("csr_wait_1", 10'b11111_00000);
        v_done = 1'b1;
        tick();
        v_done = 1'b0;
        chk_outs("csr_wait_0", 10'b11111_00000);
        tick();
        chk_outs("csr_flush", 10'b00000_11110);
        csr_update = 1'b0;
        tick();
        chk_outs("csr_back_run", 10'b00000_00000);

        // Exception inside CSR_WAIT with vcnt=3
        decode_ena = 1'b0;
        handoff();
        handoff();
        handoff();
        csr_update = 1'b1;
        tick();
        chk_outs("exc_pre_wait", 10'b11111_00000);
        exception_v = 1'b1;
        v_done = 1'b1;
        chk_outs("exc_same_cycle", 10'b00000_11111);
        tick();
        exception_v = 1'b0;
        v_done = 1'b0;
        csr_update = 1'b0;
        decode_ena = 1'b1;
        chk_outs("exc_flush", 10'b00000_11000);
        tick();
        chk_outs("exc_back_run", 10'b00000_00000);
        // Counter cleared: three hand-offs do not fill, a fourth does
        decode_ena = 1'b0;
        handoff();
        handoff();
        handoff();
        decode_ena = 1'b1;
        chk_outs("exc_cnt_cleared", 10'b00000_00000);
        decode_ena = 1'b0;
        handoff();
        decode_ena = 1'b1;
        chk_outs("exc_cnt_full", 10'b11100_00000);
        decode_ena = 1'b0;

        // Async reset in EXC_FLUSH
        exception_v = 1'b1;
        tick();
        exception_v = 1'b0;
        chk_outs("rst_in_exc", 10'b00000_11000);
        nRST = 1'b0;
        chk_outs("rst_async", 10'b00000_00000);
        chk_vdd("rst_async_vdd", 1'b0);
        @(negedge CLK);
        nRST = 1'b1;
        decode_ena = 1'b1;
        chk_outs("rst_cnt_zero", 10'b00000_00000);
        decode_ena = 1'b0;
        csr_update = 1'b1;
        tick();
        chk_outs("rst_then_csr_flush", 10'b00000_11110);
        csr_update = 1'b0;
        tick();
        chk_outs("final_run", 10'b00000_00000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
